// File: rtl/inst_fetch_if.sv
// Handshake/bus bundle between the fetch stage and its controller: memory load port,
// run control, redirect, and the instruction stream presented to the core.
interface inst_fetch_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;
   logic              start;
   logic              stall;
   logic              redirect_en;
   logic [31:0]       redirect_pc;
   logic [31:0]       Inst;
   logic [31:0]       inst_pc;
   logic              inst_valid;
   logic              halted;

   modport master (
      output load_en, load_addr, load_data, start, stall, redirect_en, redirect_pc,
      input  Inst, inst_pc, inst_valid, halted
   );

   modport slave (
      input  load_en, load_addr, load_data, start, stall, redirect_en, redirect_pc,
      output Inst, inst_pc, inst_valid, halted
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: word-addressed instruction memory, byte PC, registered
// instruction output with stall, redirect/flush and a halt sentinel.
module inst_fetch #(
   parameter int unsigned ADDR_W    = 6,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_INST = 32'hFC00_0000
) (
   input logic         clk,
   input logic         rst,
   inst_fetch_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t            state, state_nxt;
   logic [31:0]       mem [2**ADDR_W];
   logic [31:0]       pc, pc_nxt;
   logic [31:0]       inst_r, inst_nxt;
   logic [31:0]       ipc_r, ipc_nxt;
   logic              valid_r, valid_nxt;
   logic              halted_r, halted_nxt;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       word;
   logic              unused_bits;

   // Upper PC bits beyond the memory size are dropped, so fetches wrap around.
   assign idx         = pc[ADDR_W+1:2];
   assign word        = mem[idx];
   assign unused_bits = ^bus.redirect_pc[1:0];

   // Memory is never cleared by reset; writes only land while the core is not running.
   always_ff @(posedge clk) begin
      if (bus.load_en && state != RUN)
         mem[bus.load_addr] <= bus.load_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, HALT: if (bus.start) state_nxt = RUN;
         RUN:        if (!bus.redirect_en && !bus.stall && word == HALT_INST) state_nxt = HALT;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pc_nxt     = pc;
      inst_nxt   = inst_r;
      ipc_nxt    = ipc_r;
      valid_nxt  = valid_r;
      halted_nxt = halted_r;
      case (state)
         IDLE, HALT: begin
            if (bus.start) begin
               pc_nxt     = RESET_PC;
               inst_nxt   = 32'h0;
               valid_nxt  = 1'b0;
               halted_nxt = 1'b0;
            end
         end
         RUN: begin
            // Redirect flushes the wrong-path word and takes priority over stall.
            if (bus.redirect_en) begin
               pc_nxt    = {bus.redirect_pc[31:2], 2'b00};
               inst_nxt  = 32'h0;
               valid_nxt = 1'b0;
            end else if (bus.stall) begin
               pc_nxt = pc;
            end else if (word == HALT_INST) begin
               inst_nxt   = 32'h0;
               valid_nxt  = 1'b0;
               halted_nxt = 1'b1;
            end else begin
               inst_nxt  = word;
               ipc_nxt   = pc;
               valid_nxt = 1'b1;
               pc_nxt    = pc + 32'd4;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         inst_r   <= 32'h0;
         ipc_r    <= 32'h0;
         valid_r  <= 1'b0;
         halted_r <= 1'b0;
      end else begin
         pc       <= pc_nxt;
         inst_r   <= inst_nxt;
         ipc_r    <= ipc_nxt;
         valid_r  <= valid_nxt;
         halted_r <= halted_nxt;
      end
   end

   assign bus.Inst       = inst_r;
   assign bus.inst_pc    = ipc_r;
   assign bus.inst_valid = valid_r;
   assign bus.halted     = halted_r;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed programs with literal expectations, plus a
// behavioural fetch model compared against the DUT on every falling edge.
module tb_inst_fetch;
   localparam logic [31:0] HALT = 32'hFC00_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   inst_fetch_if #(.ADDR_W(6)) bus ();

   inst_fetch #(.ADDR_W(6), .RESET_PC(32'h0), .HALT_INST(HALT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Behavioural model: state 0 idle, 1 running, 2 halted.
   logic [31:0] m_mem [64];
   int          m_state;
   logic [31:0] m_pc, m_inst, m_ipc;
   logic        m_valid, m_halt;

   function automatic logic [5:0] widx(input logic [31:0] a);
      logic [31:0] w;
      w = (a / 32'd4) % 32'd64;
      return w[5:0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state <= 0; m_pc <= 0; m_inst <= 0; m_ipc <= 0; m_valid <= 0; m_halt <= 0;
      end else if (m_state != 1) begin
         if (bus.load_en) m_mem[bus.load_addr] <= bus.load_data;
         if (bus.start) begin
            m_state <= 1; m_pc <= 0; m_halt <= 0; m_inst <= 0; m_valid <= 0;
         end
      end else if (bus.redirect_en) begin
         m_pc <= bus.redirect_pc & ~32'd3; m_inst <= 0; m_valid <= 0;
      end else if (!bus.stall) begin
         if (m_mem[widx(m_pc)] === HALT) begin
            m_state <= 2; m_halt <= 1; m_inst <= 0; m_valid <= 0;
         end else begin
            m_inst <= m_mem[widx(m_pc)]; m_ipc <= m_pc; m_valid <= 1; m_pc <= m_pc + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model.Inst", bus.Inst, m_inst);
         chk("model.inst_valid", 32'(bus.inst_valid), 32'(m_valid));
         chk("model.halted", 32'(bus.halted), 32'(m_halt));
         if (m_valid) chk("model.inst_pc", bus.inst_pc, m_ipc);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input logic [5:0] a, input logic [31:0] d);
      bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
      tick();
      bus.load_en = 1'b0;
   endtask

   task automatic start_run();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] i, input logic [31:0] p,
                             input logic v, input logic h);
      chk({tag, ".Inst"}, bus.Inst, i);
      chk({tag, ".valid"}, 32'(bus.inst_valid), 32'(v));
      chk({tag, ".halted"}, 32'(bus.halted), 32'(h));
      if (v) chk({tag, ".pc"}, bus.inst_pc, p);
   endtask

   initial begin
      bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0; bus.start = 0;
      bus.stall = 0; bus.redirect_en = 0; bus.redirect_pc = 0;
      repeat (2) tick();
      rst = 1'b0;
      expect_out("reset", 32'h0, 32'h0, 1'b0, 1'b0);
      chk("reset.inst_pc", bus.inst_pc, 32'h0);

      // Straight-line program ending in the halt sentinel.
      load(6'd0, 32'h2001_0001);
      load(6'd1, 32'h2002_0001);
      load(6'd2, 32'h0021_0820);
      load(6'd3, HALT);
      tick();
      expect_out("idle_hold", 32'h0, 32'h0, 1'b0, 1'b0);
      start_run();
      tick(); expect_out("prog0", 32'h2001_0001, 32'd0, 1'b1, 1'b0);
      tick(); expect_out("prog1", 32'h2002_0001, 32'd4, 1'b1, 1'b0);
      tick(); expect_out("prog2", 32'h0021_0820, 32'd8, 1'b1, 1'b0);
      tick(); expect_out("halt", 32'h0, 32'h0, 1'b0, 1'b1);
      repeat (2) tick();
      expect_out("halt_stay", 32'h0, 32'h0, 1'b0, 1'b1);

      // Stall holding the word at pc 4.
      start_run();
      tick(); expect_out("st_pc0", 32'h2001_0001, 32'd0, 1'b1, 1'b0);
      tick(); expect_out("st_pc4", 32'h2002_0001, 32'd4, 1'b1, 1'b0);
      bus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(); expect_out("stall_hold", 32'h2002_0001, 32'd4, 1'b1, 1'b0);
      end
      bus.stall = 1'b0;
      tick(); expect_out("st_release", 32'h0021_0820, 32'd8, 1'b1, 1'b0);
      tick(); expect_out("st_halt", 32'h0, 32'h0, 1'b0, 1'b1);

      // Redirect to an unaligned target; low bits are dropped.
      load(6'd3, 32'h2004_0007);
      load(6'd4, HALT);
      start_run();
      tick(); expect_out("rd_pc0", 32'h2001_0001, 32'd0, 1'b1, 1'b0);
      bus.redirect_en = 1'b1; bus.redirect_pc = 32'h0000_000E;
      tick(); expect_out("rd_bubble", 32'h0, 32'h0, 1'b0, 1'b0);
      bus.redirect_en = 1'b0;
      tick(); expect_out("rd_target", 32'h2004_0007, 32'd12, 1'b1, 1'b0);
      tick(); expect_out("rd_halt", 32'h0, 32'h0, 1'b0, 1'b1);

      // Redirect together with stall: redirect wins.
      start_run();
      tick(); expect_out("rs_pc0", 32'h2001_0001, 32'd0, 1'b1, 1'b0);
      bus.stall = 1'b1; bus.redirect_en = 1'b1; bus.redirect_pc = 32'h0000_0008;
      tick(); expect_out("rs_bubble", 32'h0, 32'h0, 1'b0, 1'b0);
      bus.stall = 1'b0; bus.redirect_en = 1'b0;
      tick(); expect_out("rs_target", 32'h0021_0820, 32'd8, 1'b1, 1'b0);
      tick(); expect_out("rs_next", 32'h2004_0007, 32'd12, 1'b1, 1'b0);
      tick(); expect_out("rs_halt", 32'h0, 32'h0, 1'b0, 1'b1);

      // Asynchronous reset between edges, then restart with memory intact.
      start_run();
      tick(); tick();
      expect_out("ar_pc4", 32'h2002_0001, 32'd4, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 expect_out("async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      start_run();
      tick(); expect_out("ar_again0", 32'h2001_0001, 32'd0, 1'b1, 1'b0);
      tick(); expect_out("ar_again1", 32'h2002_0001, 32'd4, 1'b1, 1'b0);

      // Fill every word with non-halt data and run past the top of memory.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 64; i++) load(6'(i), 32'h1000_0000 + 32'(i));
      start_run();
      repeat (63) tick();
      tick(); expect_out("wrap_252", 32'h1000_003F, 32'd252, 1'b1, 1'b0);
      tick(); expect_out("wrap_256", 32'h1000_0000, 32'd256, 1'b1, 1'b0);
      tick(); expect_out("wrap_260", 32'h1000_0001, 32'd260, 1'b1, 1'b0);

      // Load together with start from HALT; loads during RUN are ignored.
      rst = 1'b1; tick(); rst = 1'b0;
      load(6'd1, 32'h2002_0001);
      load(6'd2, HALT);
      start_run();
      tick(); expect_out("ls_pc0", 32'h1000_0000, 32'd0, 1'b1, 1'b0);
      tick(); expect_out("ls_pc4", 32'h2002_0001, 32'd4, 1'b1, 1'b0);
      tick(); expect_out("ls_halt", 32'h0, 32'h0, 1'b0, 1'b1);
      bus.load_en = 1'b1; bus.load_addr = 6'd0; bus.load_data = 32'h2003_0005; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.load_addr = 6'd2; bus.load_data = 32'h1111_1111;
      tick(); expect_out("ls_new0", 32'h2003_0005, 32'd0, 1'b1, 1'b0);
      bus.load_en = 1'b0;
      tick(); expect_out("ls_pc4b", 32'h2002_0001, 32'd4, 1'b1, 1'b0);
      tick(); expect_out("ls_run_load_ignored", 32'h0, 32'h0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
